// File: rtl/pixel_write_queue.sv
// Pixel write queue: turns the full-screen loader pixel stream into linear
// framebuffer writes through a small show-ahead FIFO. Off-screen pixels are
// consumed and counted rather than written. A single frame-complete pulse is
// raised once a finished frame has fully drained.
module pixel_write_queue #(
    parameter int X_SCREEN_PIXELS = 320,
    parameter int Y_SCREEN_PIXELS = 240,
    parameter int DEPTH           = 8,
    parameter int ADDR_WIDTH      = 17,
    parameter int COLOUR_WIDTH    = 3
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic [10:0]             iX,
    input  logic [9:0]              iY,
    input  logic [COLOUR_WIDTH-1:0] iColour,
    input  logic                    iPlot,
    input  logic                    iDone,
    output logic                    oReady,
    input  logic                    iMemReady,
    output logic [ADDR_WIDTH-1:0]   oAddr,
    output logic [COLOUR_WIDTH-1:0] oData,
    output logic                    oWren,
    output logic                    oFrameDone,
    output logic [15:0]             oClipCount
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int OCC_WIDTH = PTR_WIDTH + 1;

    localparam logic [OCC_WIDTH-1:0]  OCC_FULL  = OCC_WIDTH'(DEPTH);
    localparam logic [OCC_WIDTH-1:0]  OCC_EMPTY = {OCC_WIDTH{1'b0}};
    localparam logic [OCC_WIDTH-1:0]  OCC_ONE   = OCC_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0]  PTR_ONE   = PTR_WIDTH'(1);
    localparam logic [31:0]           X_LIMIT   = 32'(X_SCREEN_PIXELS);
    localparam logic [31:0]           Y_LIMIT   = 32'(Y_SCREEN_PIXELS);
    localparam logic [ADDR_WIDTH-1:0] ROW_PITCH = ADDR_WIDTH'(X_SCREEN_PIXELS);
    localparam logic [15:0]           CLIP_MAX  = 16'hFFFF;

    // Queue storage and state
    logic [ADDR_WIDTH-1:0]   addrMem_r   [DEPTH];
    logic [COLOUR_WIDTH-1:0] colourMem_r [DEPTH];
    logic [PTR_WIDTH-1:0]    wrPtr_r;
    logic [PTR_WIDTH-1:0]    rdPtr_r;
    logic [OCC_WIDTH-1:0]    occupancy_r;
    logic                    donePending_r;
    logic                    doneQ_r;
    logic [15:0]             clipCount_r;
    logic [ADDR_WIDTH-1:0]   addrOut_r;
    logic [COLOUR_WIDTH-1:0] dataOut_r;

    // Per-cycle decisions
    logic                    ready_s;
    logic                    accept_s;
    logic                    inRange_s;
    logic                    push_s;
    logic                    clip_s;
    logic                    pop_s;
    logic                    doneRise_s;
    logic                    frameDone_s;
    logic                    headFromInput_s;
    logic [ADDR_WIDTH-1:0]   pixelAddr_s;
    logic [PTR_WIDTH-1:0]    rdPtrNext_s;
    logic [OCC_WIDTH-1:0]    occNext_s;

    // Accept/clip/dequeue decisions and the next-state queue bookkeeping.
    // The address is formed modulo 2^ADDR_WIDTH, which equals truncating the
    // full-precision product-plus-offset.
    always_comb begin
        ready_s     = (occupancy_r < OCC_FULL);
        accept_s    = iPlot && ready_s;
        inRange_s   = (32'(iX) < X_LIMIT) && (32'(iY) < Y_LIMIT);
        push_s      = accept_s && inRange_s;
        clip_s      = accept_s && !inRange_s;
        pop_s       = (occupancy_r != OCC_EMPTY) && iMemReady;
        doneRise_s  = iDone && !doneQ_r;
        frameDone_s = donePending_r && (occupancy_r == OCC_EMPTY) && !push_s;
        pixelAddr_s = (ADDR_WIDTH'(iY) * ROW_PITCH) + ADDR_WIDTH'(iX);

        if (pop_s) begin
            rdPtrNext_s = rdPtr_r + PTR_ONE;
        end else begin
            rdPtrNext_s = rdPtr_r;
        end

        case ({push_s, pop_s})
            2'b10:   occNext_s = occupancy_r + OCC_ONE;
            2'b01:   occNext_s = occupancy_r - OCC_ONE;
            default: occNext_s = occupancy_r;
        endcase

        // The incoming pixel becomes the head when nothing older survives this edge
        if (push_s && ((occupancy_r == OCC_EMPTY) || ((occupancy_r == OCC_ONE) && pop_s))) begin
            headFromInput_s = 1'b1;
        end else begin
            headFromInput_s = 1'b0;
        end
    end

    // Entry storage; contents need no reset since occupancy guards every read
    always_ff @(posedge iClock) begin
        if (push_s) begin
            addrMem_r[wrPtr_r]   <= pixelAddr_s;
            colourMem_r[wrPtr_r] <= iColour;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            wrPtr_r     <= {PTR_WIDTH{1'b0}};
            rdPtr_r     <= {PTR_WIDTH{1'b0}};
            occupancy_r <= OCC_EMPTY;
        end else begin
            if (push_s) begin
                wrPtr_r <= wrPtr_r + PTR_ONE;
            end
            rdPtr_r     <= rdPtrNext_s;
            occupancy_r <= occNext_s;
        end
    end

    // Registered show-ahead head: loads the entry that will be at the head after
    // this edge, and holds the last written values once the queue empties
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            addrOut_r <= {ADDR_WIDTH{1'b0}};
            dataOut_r <= {COLOUR_WIDTH{1'b0}};
        end else if (headFromInput_s) begin
            addrOut_r <= pixelAddr_s;
            dataOut_r <= iColour;
        end else if (occNext_s != OCC_EMPTY) begin
            addrOut_r <= addrMem_r[rdPtrNext_s];
            dataOut_r <= colourMem_r[rdPtrNext_s];
        end
    end

    // Saturating count of consumed off-screen pixels
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            clipCount_r <= 16'd0;
        end else if (clip_s && (clipCount_r != CLIP_MAX)) begin
            clipCount_r <= clipCount_r + 16'd1;
        end
    end

    // Frame-done tracking: a rising iDone arms the pulse, which fires once the
    // queue is empty with no pixel arriving; rises while armed merge into it
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            doneQ_r       <= 1'b0;
            donePending_r <= 1'b0;
        end else begin
            doneQ_r <= iDone;
            if (frameDone_s) begin
                donePending_r <= 1'b0;
            end else if (doneRise_s) begin
                donePending_r <= 1'b1;
            end
        end
    end

    assign oReady     = ready_s;
    assign oWren      = (occupancy_r != OCC_EMPTY);
    assign oAddr      = addrOut_r;
    assign oData      = dataOut_r;
    assign oFrameDone = frameDone_s;
    assign oClipCount = clipCount_r;

endmodule
